alu_operand_wb: RTL and testbench

Operand-issue and write-back stage wrapped around the `slt_mod` comparator (and any ALU slice with the same R1/R2/R3/c_out port shape).
- Holds a small register file and, on a handshake, drives two registered operands onto R2/R3.
- Waits one settle cycle for the combinational slice, then captures R1 and c_out back into the register file and a flag register.
- Replaces the free-running operand sweeps used in bench-only setups, so the ALU slice can be driven from RTL.

---
 rtl/alu_operand_wb.sv | 113 +++++++++++
 tb/tb_alu_operand_wb.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_wb.sv
// alu_operand_wb
//
// Operand-issue / write-back stage for a combinational ALU slice with the
// R1/R2/R3/c_out port shape (e.g. slt_mod). A small register file feeds two
// registered operands to the slice on a valid/ready handshake. After one
// settle cycle, the result and carry are written back into the file and a
// flag register.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   operation handshake (ready only in IDLE)
//   a_sel, b_sel        register indices driven onto R2 / R3
//   dst_sel             register index written with R1 at write-back
//   R2, R3              registered operands to the ALU slice
//   R1, c_in            result and carry-out returned by the ALU slice
//   ld_en/ld_addr/ld_data  direct register load, honoured only in IDLE
//   rd_addr/rd_data     combinational debug read of the register file
//   done                one-cycle pulse after a write-back
//   c_flag              c_in captured at the last write-back
//   op_count            completed operations, modulo 256

module alu_operand_wb #(
    parameter int size = 4,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   a_sel,
    input  logic [AW-1:0]   b_sel,
    input  logic [AW-1:0]   dst_sel,
    output logic [size-1:0] R2,
    output logic [size-1:0] R3,
    input  logic [size-1:0] R1,
    input  logic            c_in,
    input  logic            ld_en,
    input  logic [AW-1:0]   ld_addr,
    input  logic [size-1:0] ld_data,
    input  logic [AW-1:0]   rd_addr,
    output logic [size-1:0] rd_data,
    output logic            done,
    output logic            c_flag,
    output logic [7:0]      op_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [size-1:0] rf [NREG];
    logic [AW-1:0]   dst_q;
    logic            accept;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid & in_ready;
    assign rd_data  = rf[rd_addr];

    // ISSUE is the settle cycle for the combinational slice; CAPTURE ends
    // with the write-back edge and a return to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            R2       <= '0;
            R3       <= '0;
            dst_q    <= '0;
            done     <= 1'b0;
            c_flag   <= 1'b0;
            op_count <= 8'd0;
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            done  <= 1'b0;

            // Loads are dropped outside IDLE. Operand reads below see the
            // pre-edge file contents, so a same-cycle load is not forwarded.
            if ((state == IDLE) && ld_en) begin
                rf[ld_addr] <= ld_data;
            end

            if (accept) begin
                dst_q <= dst_sel;
                R2    <= rf[a_sel];
                R3    <= rf[b_sel];
            end

            if (state == CAPTURE) begin
                rf[dst_q] <= R1;
                c_flag    <= c_in;
                op_count  <= op_count + 8'd1;
                done      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_wb.sv
// Testbench for alu_operand_wb with an slt-style slice model on R1/c_in:
// R1 = signed(R2) < signed(R3), c_in = unsigned(R2) < unsigned(R3).
module tb_alu_operand_wb;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] a_sel, b_sel, dst_sel;
    logic [3:0] R2, R3, R1;
    logic       c_in;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [3:0] ld_data;
    logic [1:0] rd_addr;
    logic [3:0] rd_data;
    logic       done;
    logic       c_flag;
    logic [7:0] op_count;

    int checks   = 0;
    int failures = 0;

    alu_operand_wb #(.size(4), .NREG(4), .AW(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_sel    (a_sel),
        .b_sel    (b_sel),
        .dst_sel  (dst_sel),
        .R2       (R2),
        .R3       (R3),
        .R1       (R1),
        .c_in     (c_in),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .done     (done),
        .c_flag   (c_flag),
        .op_count (op_count)
    );

    // Comparator slice model
    assign R1   = ($signed(R2) < $signed(R3)) ? 4'h1 : 4'h0;
    assign c_in = (R2 < R3);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; ld_en = 1'b1; ld_addr = 2'd1; ld_data = 4'hF;
        a_sel = 2'd0; b_sel = 2'd0; dst_sel = 2'd0; rd_addr = 2'd0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            rd_addr = i[1:0];
            #1;
            checks++;
            if (rd_data !== 4'h0) begin
                failures++;
                $display("[TB] FAIL reset_rf%0d got=%h exp=0", i, rd_data);
            end
        end
        checks++;
        if (R2 !== 4'h0 || R3 !== 4'h0) begin
            failures++;
            $display("[TB] FAIL reset_operands got R2=%h R3=%h exp=0/0", R2, R3);
        end
        checks++;
        if (in_ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl got ready=%b done=%b exp=1/0", in_ready, done);
        end
        rst_n = 1'b1; ld_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || op_count !== 8'd0 || in_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL idle_quiet cyc%0d got done=%b cnt=%0d ready=%b exp=0/0/1",
                         i, done, op_count, in_ready);
            end
        end
    endtask

    task automatic test_basic_slt;
        ld_en = 1'b1; ld_addr = 2'd0; ld_data = 4'hC;
        tick();
        ld_addr = 2'd1; ld_data = 4'hD;
        tick();
        ld_en = 1'b0;
        in_valid = 1'b1; a_sel = 2'd0; b_sel = 2'd1; dst_sel = 2'd2;
        tick();                                   // E0: accept
        in_valid = 1'b0;
        checks++;
        if (R2 !== 4'hC || R3 !== 4'hD) begin
            failures++;
            $display("[TB] FAIL basic_operands got R2=%h R3=%h exp=C/D", R2, R3);
        end
        checks++;
        if (in_ready !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_busy got ready=%b done=%b exp=0/0", in_ready, done);
        end
        tick();                                   // E1
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_early_done got=%b exp=0", done);
        end
        tick();                                   // E2: write-back
        rd_addr = 2'd2;
        #1;
        checks++;
        if (done !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_done got done=%b ready=%b exp=1/1", done, in_ready);
        end
        checks++;
        if (rd_data !== 4'h1 || c_flag !== 1'b1 || op_count !== 8'd1) begin
            failures++;
            $display("[TB] FAIL basic_wb got rf2=%h c=%b cnt=%0d exp=1/1/1", rd_data, c_flag, op_count);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_done_pulse got=%b exp=0", done);
        end
    endtask

    task automatic test_self_overwrite;
        ld_en = 1'b1; ld_addr = 2'd0; ld_data = 4'h3;
        tick();
        ld_en = 1'b0;
        in_valid = 1'b1; a_sel = 2'd0; b_sel = 2'd0; dst_sel = 2'd0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (R2 !== 4'h3 || R3 !== 4'h3) begin
            failures++;
            $display("[TB] FAIL self_operands got R2=%h R3=%h exp=3/3", R2, R3);
        end
        tick();
        tick();
        rd_addr = 2'd0;
        #1;
        checks++;
        if (rd_data !== 4'h0 || done !== 1'b1 || c_flag !== 1'b0 || op_count !== 8'd2) begin
            failures++;
            $display("[TB] FAIL self_wb got rf0=%h done=%b c=%b cnt=%0d exp=0/1/0/2",
                     rd_data, done, c_flag, op_count);
        end
    endtask

    task automatic test_busy_reject;
        // rf0=0, rf1=D, rf2=1, rf3=0
        in_valid = 1'b1; a_sel = 2'd1; b_sel = 2'd0; dst_sel = 2'd2;
        tick();                                   // E0, now ISSUE
        a_sel = 2'd0; b_sel = 2'd0; dst_sel = 2'd3;
        ld_en = 1'b1; ld_addr = 2'd3; ld_data = 4'hF;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL busy_ready got=%b exp=0", in_ready);
        end
        tick();                                   // E1, now CAPTURE
        in_valid = 1'b0; ld_en = 1'b0;
        tick();                                   // E2
        checks++;
        if (R2 !== 4'hD || R3 !== 4'h0) begin
            failures++;
            $display("[TB] FAIL busy_operands_held got R2=%h R3=%h exp=D/0", R2, R3);
        end
        rd_addr = 2'd3;
        #1;
        checks++;
        if (rd_data !== 4'h0) begin
            failures++;
            $display("[TB] FAIL busy_rf3 got=%h exp=0", rd_data);
        end
        rd_addr = 2'd2;
        #1;
        checks++;
        if (rd_data !== 4'h1 || done !== 1'b1 || c_flag !== 1'b0 || op_count !== 8'd3) begin
            failures++;
            $display("[TB] FAIL busy_wb got rf2=%h done=%b c=%b cnt=%0d exp=1/1/0/3",
                     rd_data, done, c_flag, op_count);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || done !== 1'b0 || op_count !== 8'd3) begin
            failures++;
            $display("[TB] FAIL busy_no_extra got ready=%b done=%b cnt=%0d exp=1/0/3",
                     in_ready, done, op_count);
        end
    endtask

    task automatic test_load_and_accept;
        ld_en = 1'b1; ld_addr = 2'd1; ld_data = 4'h7;
        in_valid = 1'b1; a_sel = 2'd1; b_sel = 2'd0; dst_sel = 2'd3;
        tick();
        ld_en = 1'b0; in_valid = 1'b0;
        rd_addr = 2'd1;
        #1;
        checks++;
        if (R2 !== 4'hD || R3 !== 4'h0) begin
            failures++;
            $display("[TB] FAIL ldacc_operands got R2=%h R3=%h exp=D/0", R2, R3);
        end
        checks++;
        if (rd_data !== 4'h7) begin
            failures++;
            $display("[TB] FAIL ldacc_rf1 got=%h exp=7", rd_data);
        end
        tick();
        tick();
        rd_addr = 2'd3;
        #1;
        checks++;
        if (rd_data !== 4'h1 || done !== 1'b1 || op_count !== 8'd4) begin
            failures++;
            $display("[TB] FAIL ldacc_wb got rf3=%h done=%b cnt=%0d exp=1/1/4", rd_data, done, op_count);
        end
    endtask

    task automatic test_reset_mid;
        ld_en = 1'b1; ld_addr = 2'd0; ld_data = 4'hC;
        tick();
        ld_addr = 2'd1; ld_data = 4'hD;
        tick();
        ld_en = 1'b0;
        in_valid = 1'b1; a_sel = 2'd0; b_sel = 2'd1; dst_sel = 2'd2;
        tick();                                   // E0
        in_valid = 1'b0;
        tick();                                   // E1, now CAPTURE
        rst_n = 1'b0;
        tick();                                   // reset edge replaces write-back
        checks++;
        if (done !== 1'b0 || op_count !== 8'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rstmid_ctrl got done=%b cnt=%0d ready=%b exp=0/0/1",
                     done, op_count, in_ready);
        end
        checks++;
        if (R2 !== 4'h0 || R3 !== 4'h0 || c_flag !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_regs got R2=%h R3=%h c=%b exp=0/0/0", R2, R3, c_flag);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_late_done got=%b exp=0", done);
        end
        for (int i = 0; i < 4; i++) begin
            rd_addr = i[1:0];
            #1;
            checks++;
            if (rd_data !== 4'h0) begin
                failures++;
                $display("[TB] FAIL rstmid_rf%0d got=%h exp=0", i, rd_data);
            end
        end
    endtask

    task automatic test_back_to_back;
        int n_done;
        int cyc;
        int last_cyc;
        bit seen_255;
        n_done   = 0;
        last_cyc = 0;
        seen_255 = 1'b0;
        in_valid = 1'b1; a_sel = 2'd0; b_sel = 2'd0; dst_sel = 2'd1;
        for (cyc = 1; cyc <= 1000; cyc++) begin
            tick();
            if (done === 1'b1) begin
                n_done++;
                last_cyc = cyc;
                if (n_done == 255) begin
                    seen_255 = 1'b1;
                    checks++;
                    if (op_count !== 8'd255) begin
                        failures++;
                        $display("[TB] FAIL b2b_count255 got=%0d exp=255", op_count);
                    end
                end
                if (n_done == 256) break;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (n_done != 256 || !seen_255) begin
            failures++;
            $display("[TB] FAIL b2b_timeout got done_pulses=%0d exp=256", n_done);
        end
        checks++;
        if (last_cyc != 768) begin
            failures++;
            $display("[TB] FAIL b2b_throughput got last_done_cycle=%0d exp=768", last_cyc);
        end
        checks++;
        if (op_count !== 8'd0) begin
            failures++;
            $display("[TB] FAIL b2b_wrap got=%0d exp=0", op_count);
        end
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_drain got ready=%b done=%b exp=1/0", in_ready, done);
        end
    endtask

    initial begin
        test_reset();
        test_basic_slt();
        test_self_overwrite();
        test_busy_reject();
        test_load_and_accept();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
